uart_cmd_controller: RTL and testbench



---
 rtl/uart_cmd_controller.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_controller.sv
`timescale 1ns/1ps
// uart_cmd_controller
// Parses SOF/ADDR/LEN/payload/CHK frames from the UART byte stream.
// Each good payload is replayed as a burst of byte writes to a register file.
// Bad frames (length, checksum, inter-byte timeout) are dropped whole.
// A byte arriving during a burst is dropped and flagged as an overrun.
//
// Byte input: rx_valid is a one-cycle strobe, and rx_data is meaningful
// only in that cycle. There is no back-pressure, so a byte that cannot be
// taken is lost and reported on frame_err/err_code.
//
// Every output is a register. dbg_state mirrors the FSM state so a checker
// can follow the parser without reaching into the hierarchy.
module uart_cmd_controller #(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 9_090_900,
    parameter logic [7:0] SOF_BYTE     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic [2:0] dbg_state
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CLKS);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    // Expiry is flagged on the edge where the idle count would reach
    // TIMEOUT_CLKS-1, so the error lands TIMEOUT_CLKS-1 edges after the last byte.
    localparam logic [CW-1:0] TMO_FIRE  = CW'(TIMEOUT_CLKS - 2);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CHK     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_base;
    logic [7:0]    r_chk;
    logic [IW-1:0] r_len;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_widx;
    logic [CW-1:0] r_tmo;

    logic          r_wr_en;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_frame_err;
    logic [2:0]    r_err_code;

    logic [7:0]    r_buf [MAX_LEN];

    wire           w_buf_we = (r_state == S_DATA) && rx_valid;

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign err_code   = r_err_code;
    assign dbg_state  = r_state;

    // Payload buffer: filled in DATA, read back in order during COMMIT; no reset needed.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx[AW-1:0]] <= rx_data;
        end
    end

    // Frame parser, inter-byte timeout and commit sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= 8'd0;
            r_chk        <= 8'd0;
            r_len        <= '0;
            r_idx        <= '0;
            r_widx       <= '0;
            r_tmo        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 8'd0;
            r_wr_data    <= 8'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= 3'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_tmo   <= '0;
                    r_wr_en <= 1'b0;
                    // Anything other than SOF is line noise and is ignored silently.
                    if (rx_valid && (rx_data == SOF_BYTE)) begin
                        r_state <= S_ADDR;
                        r_busy  <= 1'b1;
                    end
                end

                S_COMMIT: begin
                    r_tmo <= '0;
                    // No room for a new frame yet: drop the byte, keep writing.
                    if (rx_valid) begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_OVERRUN;
                    end
                    if (r_widx == r_len) begin
                        r_wr_en      <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_base + 8'(r_widx);
                        r_wr_data <= r_buf[r_widx[AW-1:0]];
                        r_widx    <= r_widx + IW'(1);
                    end
                end

                // ADDR, LEN, DATA and CHK all wait on a byte under the timeout.
                default: begin
                    if (rx_valid) begin
                        // A byte on the expiry cycle wins over the timeout.
                        r_tmo <= '0;
                        case (r_state)
                            S_ADDR: begin
                                r_base  <= rx_data;
                                r_chk   <= rx_data;
                                r_state <= S_LEN;
                            end
                            S_LEN: begin
                                if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= ERR_LEN;
                                    r_busy      <= 1'b0;
                                    r_state     <= S_IDLE;
                                end else begin
                                    r_len   <= rx_data[IW-1:0];
                                    r_chk   <= r_chk ^ rx_data;
                                    r_idx   <= '0;
                                    r_state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                // SOF inside a frame is plain payload; no resync.
                                r_chk <= r_chk ^ rx_data;
                                r_idx <= r_idx + IW'(1);
                                if (r_idx == (r_len - IW'(1))) begin
                                    r_state <= S_CHK;
                                end
                            end
                            S_CHK: begin
                                if (rx_data != r_chk) begin
                                    r_frame_err <= 1'b1;
                                    r_err_code  <= ERR_CHK;
                                    r_busy      <= 1'b0;
                                    r_state     <= S_IDLE;
                                end else begin
                                    // First write goes out on the very next cycle.
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_base;
                                    r_wr_data <= r_buf[0];
                                    r_widx    <= IW'(1);
                                    r_state   <= S_COMMIT;
                                end
                            end
                            default: begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end else if (r_tmo == TMO_FIRE) begin
                        r_tmo       <= '0;
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_controller.sv
`timescale 1ns/1ps
module tb_uart_cmd_controller;

  localparam int MAX_LEN      = 16;
  localparam int TIMEOUT_CLKS = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [2:0] err_code;
  logic [2:0] dbg_state;

  uart_cmd_controller #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .SOF_BYTE     (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_wr    = 0;
  int b_done;
  int b_err;
  int b_wr;

  // expected writes, {addr, data}
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every write strobe must match the head of exp_q
  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (wr_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0)
        check("unexpected_wr", {16'd0, wr_addr, wr_data}, 32'h0001_0000);
      else
        check("wr", {16'd0, wr_addr, wr_data}, {16'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    b_done = n_done;
    b_err  = n_err;
    b_wr   = n_wr;
  endtask

  task automatic expect_result(input string tag, input int d_done, input int d_err);
    settle(MAX_LEN + 4);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_done"}, n_done - b_done, d_done);
    check({tag, "_err"}, n_err - b_err, d_err);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic good_frame_1033();
    exp_q.push_back(16'h1033);
    exp_q.push_back(16'h1144);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    settle(2);

    // good frame with exact latency checks
    mark();
    good_frame_1033();
    check("f1_lat_wr_en", wr_en, 1);
    check("f1_lat_addr", wr_addr, 8'h10);
    @(negedge clk);
    check("f1_wr2_en", wr_en, 1);
    @(negedge clk);
    check("f1_done_pulse", frame_done, 1);
    check("f1_done_wr_en", wr_en, 0);
    check("f1_done_busy", busy, 0);
    check("f1_done_state", dbg_state, 0);
    expect_result("f1", 1, 0);

    // checksum failure, then a good frame
    mark();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h66);
    expect_result("ckerr", 0, 1);
    check("ckerr_code", err_code, 2);
    check("ckerr_nowr", n_wr - b_wr, 0);
    mark();
    good_frame_1033();
    expect_result("after_ck", 1, 0);

    // length errors
    mark();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00);
    expect_result("len0", 0, 1);
    check("len0_code", err_code, 1);
    mark();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
    expect_result("len17", 0, 1);
    check("len17_code", err_code, 1);

    // max length: payload 01..10, chk = 20^10^10 = 20
    mark();
    for (int i = 0; i < 16; i++) exp_q.push_back({8'h20 + 8'(i), 8'(i + 1)});
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h20);
    expect_result("len16", 1, 0);
    check("len16_count", n_wr - b_wr, 16);

    // address wrap
    mark();
    exp_q.push_back(16'hFFAA);
    exp_q.push_back(16'h00BB);
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hEC);
    expect_result("wrap", 1, 0);

    // timeout: error 99 edges after the FF strobe
    mark();
    send_byte(8'hA5); send_byte(8'hFF);
    repeat (98) @(negedge clk);
    check("tmo_early_err", frame_err, 0);
    check("tmo_early_busy", busy, 1);
    @(negedge clk);
    check("tmo_fire", frame_err, 1);
    check("tmo_code", err_code, 3);
    expect_result("tmo", 0, 1);

    // byte lands on the expiry cycle: no timeout, frame completes
    mark();
    exp_q.push_back(16'hFF77);
    send_byte(8'hA5); send_byte(8'hFF);
    repeat (97) @(negedge clk);
    send_byte(8'h01);
    check("tmo_byte_noerr", frame_err, 0);
    check("tmo_byte_busy", busy, 1);
    send_byte(8'h77); send_byte(8'h89);
    expect_result("tmo_byte", 1, 0);

    // garbage in IDLE
    mark();
    send_byte(8'h00); send_byte(8'h5A);
    expect_result("garbage", 0, 0);
    check("garbage_state", dbg_state, 0);

    // overrun on first commit cycle of a len=4 frame, chk = 40
    mark();
    exp_q.push_back(16'h4001); exp_q.push_back(16'h4102);
    exp_q.push_back(16'h4203); exp_q.push_back(16'h4304);
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h40);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("ovr_err", frame_err, 1);
    check("ovr_code", err_code, 4);
    check("ovr_wr_en", wr_en, 1);
    expect_result("ovr", 1, 1);

    // reset during DATA
    mark();
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h03); send_byte(8'h11);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstd_busy", busy, 0);
    check("rstd_state", dbg_state, 0);
    check("rstd_code", err_code, 0);
    @(negedge clk);
    rst = 1'b0;
    settle(8);
    check("rstd_nowr", n_wr - b_wr, 0);
    check("rstd_busy_after", busy, 0);

    // reset during COMMIT cycle 2, chk = 60
    mark();
    exp_q.push_back(16'h6001);
    send_byte(8'hA5); send_byte(8'h60); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h60);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstc_wr_en", wr_en, 0);
    check("rstc_wr_addr", wr_addr, 0);
    check("rstc_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    settle(8);
    check("rstc_drain", exp_q.size(), 0);
    check("rstc_wr_count", n_wr - b_wr, 1);
    check("rstc_nodone", n_done - b_done, 0);

    // normal operation after reset
    mark();
    good_frame_1033();
    expect_result("post_rst", 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
